// File: rtl/sys_defs.sv
// sys_defs: shared pipeline types for reservation-station issue and FU queues.
// Latency: n/a (types only).
// Backpressure: n/a; FU_FIFO_PACKET carries one stall bit per FU class.
package sys_defs;

  typedef enum logic [1:0] {
    ALU_1  = 2'd0,
    LS_1   = 2'd1,
    MULT_1 = 2'd2,
    BRANCH = 2'd3
  } FU_SELECT;

  typedef struct packed {
    logic [31:0] PC;
    logic [31:0] inst;
    logic [4:0]  dest_reg;
    FU_SELECT    fu_sel;
    logic        valid;
  } RS_S_PACKET;

  typedef struct packed {
    logic alu_1;
    logic ls_1;
    logic mult_1;
    logic branch;
  } FU_FIFO_PACKET;

endpackage

// File: rtl/issue_fifo_fu_wrapper.sv
// issue_fifo_fu_wrapper: one issue_fifo per FU class, stall bits packed into FU_FIFO_PACKET.
// Latency: that of issue_fifo (1 cycle, or same-cycle with ISSUE_FIFO_BYPASS_EN).
// Backpressure: fu_fifo_stall per class; each FU pops with its own fu_ready bit.
module issue_fifo_fu_wrapper
  import sys_defs::*;
#(
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  RS_S_PACKET [2:0] issue_insts,
  input  logic             squash,
  input  logic [3:0]       fu_ready,
  output RS_S_PACKET [3:0] fu_pkts,
  output logic [3:0]       fu_pkt_valid,
  output logic [3:0]       overflow,
  output FU_FIFO_PACKET    fu_fifo_stall
);

  logic [3:0] stall;

  issue_fifo #(.DEPTH(DEPTH), .FU_CLASS(ALU_1)) u_alu (
    .clock(clock), .reset(reset), .issue_insts(issue_insts), .squash(squash),
    .fu_ready(fu_ready[0]), .fu_pkt(fu_pkts[0]), .fu_pkt_valid(fu_pkt_valid[0]),
    .fu_stall(stall[0]), .overflow(overflow[0])
  );

  issue_fifo #(.DEPTH(DEPTH), .FU_CLASS(LS_1)) u_ls (
    .clock(clock), .reset(reset), .issue_insts(issue_insts), .squash(squash),
    .fu_ready(fu_ready[1]), .fu_pkt(fu_pkts[1]), .fu_pkt_valid(fu_pkt_valid[1]),
    .fu_stall(stall[1]), .overflow(overflow[1])
  );

  issue_fifo #(.DEPTH(DEPTH), .FU_CLASS(MULT_1)) u_mult (
    .clock(clock), .reset(reset), .issue_insts(issue_insts), .squash(squash),
    .fu_ready(fu_ready[2]), .fu_pkt(fu_pkts[2]), .fu_pkt_valid(fu_pkt_valid[2]),
    .fu_stall(stall[2]), .overflow(overflow[2])
  );

  issue_fifo #(.DEPTH(DEPTH), .FU_CLASS(BRANCH)) u_br (
    .clock(clock), .reset(reset), .issue_insts(issue_insts), .squash(squash),
    .fu_ready(fu_ready[3]), .fu_pkt(fu_pkts[3]), .fu_pkt_valid(fu_pkt_valid[3]),
    .fu_stall(stall[3]), .overflow(overflow[3])
  );

  assign fu_fifo_stall.alu_1  = stall[0];
  assign fu_fifo_stall.ls_1   = stall[1];
  assign fu_fifo_stall.mult_1 = stall[2];
  assign fu_fifo_stall.branch = stall[3];

endmodule

// File: rtl/issue_fifo.sv
// issue_fifo: per-FU circular issue queue taking up to 3 RS slots per cycle (order 2,1,0).
// Latency: 1 cycle write-to-head; ISSUE_FIFO_BYPASS_EN forwards into an empty queue same cycle.
// Backpressure: fu_stall when <3 entries free; writes beyond free space are dropped with overflow.
module issue_fifo
  import sys_defs::*;
#(
  parameter int       DEPTH    = 8,
  parameter FU_SELECT FU_CLASS = ALU_1
) (
  input  logic             clock,
  input  logic             reset,
  input  RS_S_PACKET [2:0] issue_insts,
  input  logic             squash,
  input  logic             fu_ready,
  output RS_S_PACKET       fu_pkt,
  output logic             fu_pkt_valid,
  output logic             fu_stall,
  output logic             overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  RS_S_PACKET    mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;

  logic          active;
  logic [2:0]    accepted;
  logic [2:0]    want;
  logic [2:0]    wr_en;
  logic [PW-1:0] wr_idx [3];
  logic          deq;
  logic          drop;
  logic          byp_act;
  logic [2:0]    byp_mask;
  int            nwr;
  int            free_slots;

  assign active = !reset && !squash;

  // Slot filter: only valid packets steered to this FU class are taken.
  always_comb begin
    accepted = '0;
    for (int k = 0; k < 3; k++) begin
      accepted[k] = issue_insts[k].valid && (issue_insts[k].fu_sel == FU_CLASS);
    end
  end

`ifdef ISSUE_FIFO_BYPASS_EN
  logic [1:0] byp_slot;

  // Empty-queue bypass: pick the first accepted slot in 2,1,0 order.
  always_comb begin
    byp_act  = active && (count == '0) && (|accepted);
    byp_slot = 2'd0;
    if (accepted[2])      byp_slot = 2'd2;
    else if (accepted[1]) byp_slot = 2'd1;
    byp_mask = '0;
    if (byp_act && fu_ready) byp_mask[byp_slot] = 1'b1;
  end
`else
  assign byp_act  = 1'b0;
  assign byp_mask = 3'b000;
`endif

  // Write allocation: consecutive tail slots in order 2,1,0; lowest slots lose when space runs out.
  always_comb begin
    want       = active ? (accepted & ~byp_mask) : 3'b000;
    deq        = active && (count != '0) && fu_ready;
    free_slots = DEPTH - int'(count) + int'(deq);
    nwr        = 0;
    drop       = 1'b0;
    wr_en      = '0;
    for (int k = 2; k >= 0; k--) begin
      wr_idx[k] = tail + PW'(nwr);
      if (want[k]) begin
        if (nwr < free_slots) begin
          wr_en[k] = 1'b1;
          nwr      = nwr + 1;
        end else begin
          drop = 1'b1;
        end
      end
    end
    count_nxt = CW'(int'(count) + nwr - int'(deq));
  end

  // Head presentation, bypass override and status flags.
  always_comb begin
    fu_pkt       = '0;
    fu_pkt_valid = 1'b0;
    if (active && (count != '0)) begin
      fu_pkt       = mem[head];
      fu_pkt_valid = 1'b1;
    end
`ifdef ISSUE_FIFO_BYPASS_EN
    if (byp_act) begin
      fu_pkt       = issue_insts[byp_slot];
      fu_pkt_valid = 1'b1;
    end
`endif
    fu_stall = !reset && ((DEPTH - int'(count)) < 3);
    overflow = drop;
  end

  // Pointer and occupancy state; squash and reset both empty the queue.
  always_ff @(posedge clock) begin
    if (reset || squash) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(deq);
      tail  <= tail + PW'(nwr);
      count <= count_nxt;
    end
  end

  // Entry storage is not reset; only pointers define what is live.
  always_ff @(posedge clock) begin
    for (int k = 0; k < 3; k++) begin
      if (wr_en[k]) mem[wr_idx[k]] <= issue_insts[k];
    end
  end

endmodule
